// File: rtl/pixel_pkg.sv
// Shared constants and encodings for the pixel pipeline.
package pixel_pkg;

    localparam int X_SIZE          = 640;
    localparam int Y_SIZE          = 480;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int AXIS_BYTES      = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [AXIS_BYTES-1:0] KEEP_1 = 4'b0001;
    localparam logic [AXIS_BYTES-1:0] KEEP_2 = 4'b0011;
    localparam logic [AXIS_BYTES-1:0] KEEP_3 = 4'b0111;
    localparam logic [AXIS_BYTES-1:0] KEEP_4 = 4'b1111;

endpackage

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into a 32-bit AXI4-Stream (4 pixels -> 3 words),
// mapping sof/eol onto tuser/tlast with optional end-of-line flush.
module rgb_stream_packer
    import pixel_pkg::*;
#(
    parameter bit FLUSH_ON_EOL = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    output logic        in_ready,
    input  logic        sof,
    input  logic        eol,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
);

    state_t      state_q, state_d;
    logic [23:0] res_q, res_d;
    logic [1:0]  n_q, n_d;
    logic        plast_q, plast_d;
    logic        puser_q, puser_d;

    logic [31:0] tdata_d;
    logic [3:0]  tkeep_d;
    logic        tlast_d, tuser_d, tvalid_d;

    logic        out_free, accept;
    logic [23:0] pix, res_eff;
    logic [1:0]  n_eff;
    logic        plast_eff, puser_eff;
    logic [47:0] cat;

    assign out_free = !out_stream_tvalid || out_stream_tready;
    assign in_ready = aresetn && (state_q == RUN) && out_free;
    assign accept   = valid && in_ready;
    assign pix      = {r, g, b};

    // sof discards residue and pending flags so the frame starts at n=0
    assign n_eff     = sof ? 2'd0 : n_q;
    assign res_eff   = sof ? 24'd0 : res_q;
    assign plast_eff = sof ? 1'b0 : plast_q;
    assign puser_eff = sof | puser_q;
    assign cat       = ({24'd0, pix} << {n_eff, 3'b000}) | {24'd0, res_eff};

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        n_d      = n_q;
        plast_d  = plast_q;
        puser_d  = puser_q;
        tdata_d  = out_stream_tdata;
        tkeep_d  = out_stream_tkeep;
        tlast_d  = out_stream_tlast;
        tuser_d  = out_stream_tuser;
        tvalid_d = out_stream_tvalid && !out_stream_tready;

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (FLUSH_ON_EOL && eol) begin
                        tvalid_d = 1'b1;
                        tuser_d  = puser_eff;
                        tdata_d  = cat[31:0];
                        tkeep_d  = KEEP_4;
                        tlast_d  = 1'b1;
                        puser_d  = 1'b0;
                        plast_d  = 1'b0;
                        res_d    = 24'd0;
                        n_d      = 2'd0;
                        if (n_eff == 2'd0) begin
                            tdata_d = {8'd0, cat[23:0]};
                            tkeep_d = KEEP_3;
                        end else if (n_eff != 2'd1) begin
                            // more than a word's worth: leftover goes out next cycle
                            tlast_d = 1'b0;
                            res_d   = {8'd0, cat[47:32]};
                            n_d     = n_eff - 2'd1;
                            state_d = FLUSH;
                        end
                    end else if (n_eff == 2'd0) begin
                        res_d   = cat[23:0];
                        n_d     = 2'd3;
                        puser_d = puser_eff;
                        plast_d = plast_eff || eol;
                    end else begin
                        tvalid_d = 1'b1;
                        tdata_d  = cat[31:0];
                        tkeep_d  = KEEP_4;
                        tuser_d  = puser_eff;
                        tlast_d  = plast_eff || (eol && n_eff == 2'd1);
                        puser_d  = 1'b0;
                        plast_d  = eol && (n_eff != 2'd1);
                        res_d    = {8'd0, cat[47:32]};
                        n_d      = n_eff - 2'd1;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = {8'd0, res_q};
                    tkeep_d  = (n_q == 2'd1) ? KEEP_1 : KEEP_2;
                    tlast_d  = 1'b1;
                    tuser_d  = 1'b0;
                    res_d    = 24'd0;
                    n_d      = 2'd0;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q           <= RUN;
            res_q             <= 24'd0;
            n_q               <= 2'd0;
            plast_q           <= 1'b0;
            puser_q           <= 1'b0;
            out_stream_tdata  <= 32'd0;
            out_stream_tkeep  <= 4'd0;
            out_stream_tlast  <= 1'b0;
            out_stream_tuser  <= 1'b0;
            out_stream_tvalid <= 1'b0;
        end else begin
            state_q           <= state_d;
            res_q             <= res_d;
            n_q               <= n_d;
            plast_q           <= plast_d;
            puser_q           <= puser_d;
            out_stream_tdata  <= tdata_d;
            out_stream_tkeep  <= tkeep_d;
            out_stream_tlast  <= tlast_d;
            out_stream_tuser  <= tuser_d;
            out_stream_tvalid <= tvalid_d;
        end
    end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Scoreboard bench for rgb_stream_packer (FLUSH_ON_EOL=1).
module tb_rgb_stream_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
    logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
    logic        in_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid;
    logic        tready = 1'b1;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int words_seen = 0;
    word_t exp_q[$];

    always #5 aclk = ~aclk;

    rgb_stream_packer #(.FLUSH_ON_EOL(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .r(r), .g(g), .b(b), .valid(valid), .in_ready(in_ready),
        .sof(sof), .eol(eol),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
        .out_stream_tlast(tlast), .out_stream_tuser(tuser),
        .out_stream_tvalid(tvalid), .out_stream_tready(tready)
    );

    // Transfers are judged half a cycle before the edge that completes them.
    always @(negedge aclk) begin
        if (aresetn && tvalid && tready) begin
            word_t got, want;
            got = '{data: tdata, keep: tkeep, last: tlast, user: tuser};
            checks++;
            words_seen++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got=%h (data/keep/last/user)", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL word got d=%h k=%b l=%b u=%b want d=%h k=%b l=%b u=%b",
                             got.data, got.keep, got.last, got.user,
                             want.data, want.keep, want.last, want.user);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        exp_q.push_back('{data: d, keep: k, last: l, user: u});
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [23:0] p, input logic s, input logic e);
        int n;
        {r, g, b} = p;
        sof = s;
        eol = e;
        valid = 1'b1;
        n = 0;
        forever begin
            @(negedge aclk);
            if (in_ready) break;
            stalls++;
            n++;
            if (n > 1000) begin
                errors++;
                checks++;
                $display("FAIL send_timeout pixel=%h in_ready stuck at 0", p);
                break;
            end
        end
        @(posedge aclk);
        #1;
        valid = 1'b0;
        sof = 1'b0;
        eol = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        checks++;
        if ({tvalid, tkeep, tlast, tuser, tdata, in_ready} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b k=%b l=%b u=%b d=%h rdy=%b want all 0",
                     tvalid, tkeep, tlast, tuser, tdata, in_ready);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic();
        stalls = 0;
        push(32'h66112233, 4'hF, 1'b0, 1'b1);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'hAABBCC77, 4'hF, 1'b0, 1'b0);
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b0);
        wait_drain();
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL basic_in_ready stalls=%0d want 0", stalls);
        end
    endtask

    task automatic test_line();
        logic [23:0] px[640];
        logic [7:0]  bytes[$];
        logic [31:0] w;
        int start;
        for (int i = 0; i < 640; i++) begin
            px[i] = 24'($urandom);
            bytes.push_back(px[i][7:0]);
            bytes.push_back(px[i][15:8]);
            bytes.push_back(px[i][23:16]);
        end
        for (int i = 0; i < 480; i++) begin
            w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            push(w, 4'hF, i == 479, i == 0);
        end
        stalls = 0;
        start = words_seen;
        for (int i = 0; i < 640; i++) send(px[i], i == 0, i == 639);
        wait_drain();
        checks++;
        if (words_seen - start != 480) begin
            errors++;
            $display("FAIL line_words got=%0d want 480", words_seen - start);
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL line_no_flush stalls=%0d want 0", stalls);
        end
    endtask

    task automatic test_eol_flush();
        push(32'h66112233, 4'hF, 1'b0, 1'b0);
        push(32'h00004455, 4'h3, 1'b1, 1'b0);
        send(24'h112233, 1'b0, 1'b0);
        send(24'h445566, 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL eol_flush_ready got=%b want 0", in_ready);
        end
        @(negedge aclk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL eol_flush_ready_back got=%b want 1", in_ready);
        end
        @(posedge aclk);
        #1;
        // single pixel carrying both sof and eol: short word at n=0
        push(32'h00AABBCC, 4'h7, 1'b1, 1'b1);
        send(24'hAABBCC, 1'b1, 1'b1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        push(32'h66112233, 4'hF, 1'b0, 1'b1);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'hAABBCC77, 4'hF, 1'b0, 1'b0);
        tready = 1'b0;
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        fork
            begin
                send(24'h778899, 1'b0, 1'b0);
                send(24'hAABBCC, 1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    checks++;
                    if (tvalid !== 1'b1 || tdata !== 32'h66112233 || tkeep !== 4'hF
                        || tuser !== 1'b1 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d v=%b d=%h k=%b u=%b rdy=%b want v=1 d=66112233 k=1111 u=1 rdy=0",
                                 i, tvalid, tdata, tkeep, tuser, in_ready);
                    end
                end
                @(posedge aclk);
                #1;
                tready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_sof_resync();
        push(32'h06010203, 4'hF, 1'b0, 1'b0);
        push(32'h33AABBCC, 4'hF, 1'b0, 1'b1);
        push(32'h55661122, 4'hF, 1'b0, 1'b0);
        push(32'h00000044, 4'h1, 1'b1, 1'b0);
        send(24'h010203, 1'b0, 1'b0);
        send(24'h040506, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b1, 1'b0);
        send(24'h112233, 1'b0, 1'b0);
        send(24'h445566, 1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int start;
        tready = 1'b0;
        exp_q.push_back('{data: 32'h66112233, keep: 4'hF, last: 1'b0, user: 1'b1});
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({tvalid, tkeep, tlast, tuser} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b k=%b l=%b u=%b want all 0",
                     tvalid, tkeep, tlast, tuser);
        end
        exp_q.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tready = 1'b1;
        start = words_seen;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (words_seen != start || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle words=%0d v=%b want 0 words, v=0",
                     words_seen - start, tvalid);
        end
        push(32'hCC778899, 4'hF, 1'b0, 1'b0);
        push(32'hEEFFAABB, 4'hF, 1'b0, 1'b0);
        push(32'h010203DD, 4'hF, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b0);
        send(24'hDDEEFF, 1'b0, 1'b0);
        send(24'h010203, 1'b0, 1'b0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_line();
        test_eol_flush();
        test_backpressure();
        test_sof_resync();
        test_reset_mid();
        repeat (2) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
